// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Brief   : Single-port 32-bit data memory with a four-phase request/ready
//           handshake, programmable wait states and range/opcode checking.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRd,
  input  logic        memWr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [1:0]  state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      op_q, op_d;
  logic            errf_q, errf_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH];

  logic            w_req;
  logic            w_req_err;
  logic            w_enter_resp;
  logic [AW-1:0]   w_c_addr;
  logic [31:0]     w_c_wdata;
  logic [1:0]      w_c_op;
  logic            w_c_err;
  logic            w_mem_we;

  assign w_req     = memRd | memWr;
  assign w_req_err = ((addr >> AW) != 32'd0) | (memRd & memWr);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    errf_d       = errf_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    ready_d      = 1'b0;
    err_d        = 1'b0;
    w_enter_resp = 1'b0;
    w_c_addr     = addr_q;
    w_c_wdata    = wdata_q;
    w_c_op       = op_q;
    w_c_err      = errf_q;

    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          addr_d  = addr[AW-1:0];
          wdata_d = wdata;
          op_d    = {memRd, memWr};
          errf_d  = w_req_err;
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: the response is formed from the live request.
            state_d      = S_RESP;
            w_enter_resp = 1'b1;
            w_c_addr     = addr[AW-1:0];
            w_c_wdata    = wdata;
            w_c_op       = {memRd, memWr};
            w_c_err      = w_req_err;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: state_d = S_DONE;
      S_DONE: begin
        if (!memRd && !memWr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_enter_resp) begin
      ready_d = 1'b1;
      err_d   = w_c_err;
      if (w_c_op[1]) rdata_d = w_c_err ? 32'h0 : mem_q[w_c_addr];
    end
  end

  assign w_mem_we = w_enter_resp & w_c_op[0] & ~w_c_err & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      op_q    <= 2'b00;
      errf_q  <= 1'b0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      errf_q  <= errf_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset by design.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem_q[w_c_addr] <= w_c_wdata;
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q != S_IDLE);
  assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_responder
// Brief   : Directed + randomized self-checking bench for data_mem_responder,
//           one instance with two wait states and one with none.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [31:0] ad_s   [2];
  logic [31:0] wd_s   [2];
  logic [31:0] rdat_s [2];
  logic        rdy_s  [2];
  logic        err_s  [2];
  logic        busy_s [2];
  logic [1:0]  st_s   [2];

  int          c_depth [2] = '{256, 16};
  int          c_wait  [2] = '{2, 0};

  logic [31:0] mdl [int];
  logic [31:0] last_rd [2];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset), .memRd(rd_s[0]), .memWr(wr_s[0]),
    .addr(ad_s[0]), .wdata(wd_s[0]), .rdata(rdat_s[0]), .ready(rdy_s[0]),
    .err(err_s[0]), .busy(busy_s[0]), .state(st_s[0])
  );

  data_mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .memRd(rd_s[1]), .memWr(wr_s[1]),
    .addr(ad_s[1]), .wdata(wd_s[1]), .rdata(rdat_s[1]), .ready(rdy_s[1]),
    .err(err_s[1]), .busy(busy_s[1]), .state(st_s[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input int i);
    chk("rst_state", 32'(st_s[i]), 32'd0);
    chk("rst_ready", 32'(rdy_s[i]), 32'd0);
    chk("rst_err",   32'(err_s[i]), 32'd0);
    chk("rst_busy",  32'(busy_s[i]), 32'd0);
    chk("rst_rdata", rdat_s[i], 32'h0);
  endtask

  task automatic start(input int i, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rd_s[i] = rd; wr_s[i] = wr; ad_s[i] = a; wd_s[i] = d;
  endtask

  // Waits for the ready pulse, checks it against the reference model, then
  // holds the strobes for `hold` extra cycles and releases them.
  task automatic complete(input int i, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input int hold);
    int          lat = -1;
    bit          saw_wait = 0;
    logic        e;
    logic [31:0] exp_rd;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (st_s[i] == 2'd1) saw_wait = 1;
      if (rdy_s[i]) begin lat = c; break; end
      ad_s[i] = $urandom; wd_s[i] = $urandom;
    end
    e = (a >= 32'(c_depth[i])) || (rd && wr);
    if (rd) exp_rd = e ? 32'h0 : mdl[i * 65536 + int'(a)];
    else    exp_rd = last_rd[i];
    if (wr && !e) mdl[i * 65536 + int'(a)] = d;
    last_rd[i] = exp_rd;
    chk("latency", 32'(lat), 32'(c_wait[i] + 1));
    chk("wait_seen", 32'(saw_wait), 32'(c_wait[i] > 0));
    chk("err", 32'(err_s[i]), 32'(e));
    chk("rdata", rdat_s[i], exp_rd);
    chk("resp_state", 32'(st_s[i]), 32'd2);
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk); #1;
      chk("done_state", 32'(st_s[i]), 32'd3);
      chk("done_ready", 32'(rdy_s[i]), 32'd0);
      chk("done_rdata", rdat_s[i], exp_rd);
    end
    @(negedge clk);
    rd_s[i] = 1'b0; wr_s[i] = 1'b0;
    @(posedge clk); #1;
    chk("idle_state", 32'(st_s[i]), 32'd0);
    chk("idle_busy", 32'(busy_s[i]), 32'd0);
  endtask

  task automatic txn(input int i, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d, input int hold);
    start(i, rd, wr, a, d);
    complete(i, rd, wr, a, d, hold);
  endtask

  initial begin
    int          k;
    logic [31:0] a;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd_s[i] = 0; wr_s[i] = 0; ad_s[i] = 0; wd_s[i] = 0; last_rd[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++) txn(i, 0, 1, 32'(j), $urandom, 0);

    // Write then read back with the default two wait states.
    txn(0, 0, 1, 32'd5, 32'hDEADBEEF, 0);
    txn(0, 1, 0, 32'd5, 32'h0, 0);
    // Out-of-range read exactly at DEPTH, then a neighbour read.
    txn(0, 1, 0, 32'd256, 32'h0, 0);
    txn(0, 1, 0, 32'd0, 32'h0, 0);
    txn(0, 0, 1, 32'd300, 32'h5A5A5A5A, 0);
    // Both strobes high is rejected and must not disturb the array.
    txn(0, 0, 1, 32'd7, 32'h1234, 0);
    txn(0, 1, 1, 32'd7, 32'hFFFF0000, 0);
    txn(0, 1, 0, 32'd7, 32'h0, 0);
    // Strobe held well after ready.
    txn(0, 1, 0, 32'd5, 32'h0, 5);

    // Reset during WAIT of a write: the write is lost.
    txn(0, 0, 1, 32'd9, 32'hAAAA, 0);
    start(0, 0, 1, 32'd9, 32'h5555);
    @(posedge clk); #1;
    chk("wait_before_rst", 32'(st_s[0]), 32'd1);
    @(negedge clk) reset = 1'b1;
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    rd_s[0] = 1'b1; wr_s[0] = 1'b0; ad_s[0] = 32'd9;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    @(negedge clk) reset = 1'b0;
    complete(0, 1, 0, 32'd9, 32'h0, 0);

    // Zero-wait instance.
    txn(1, 1, 0, 32'd3, 32'h0, 0);
    txn(1, 1, 0, 32'd16, 32'h0, 1);

    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 30; n++) begin
        k = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 15));
        if (k < 4)       txn(i, 1, 0, a, 32'h0, $urandom_range(0, 2));
        else if (k < 7)  txn(i, 0, 1, a, $urandom, $urandom_range(0, 2));
        else if (k == 7) txn(i, 1, 1, a, $urandom, 0);
        else begin
          a = 32'(c_depth[i]) + 32'($urandom_range(0, 3));
          if (k == 8) txn(i, 1, 0, a, 32'h0, 0);
          else        txn(i, 0, 1, a, $urandom, 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words in the data array; power of two, 2..65536.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states between request capture and response; range 0..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 memRd  input  1  read strobe from the processor; held high until ready.
REQ-006 memWr  input  1  write strobe from the processor; held high until ready.
REQ-007 addr  input  32  word address.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  registered read data; valid only while ready=1.
REQ-010 ready  output  1  registered one-cycle completion pulse.
REQ-011 err  output  1  registered; qualifies ready; 1 = transaction rejected.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 state  output  2  debug encoding: IDLE=0, WAIT=1, RESP=2, DONE=3.

Function
REQ-014 Storage SHALL be DEPTH x 32 bits, indexed by addr[log2(DEPTH)-1:0].
REQ-015 A request SHALL be sampled only in IDLE, on a rising edge with memRd|memWr=1.
REQ-016 At sampling, the block SHALL latch addr, wdata, opcode {memRd,memWr} and error flag.
- Error flag = 1 when addr >= DEPTH, or memRd and memWr are both high.
REQ-017 IDLE -> WAIT on request when WAIT_CYCLES > 0, loading the wait counter with WAIT_CYCLES-1.
REQ-018 IDLE -> RESP on request when WAIT_CYCLES = 0.
REQ-019 In WAIT, the counter SHALL decrement each cycle. WAIT -> RESP on the edge where the counter is 0. Total IDLE-exit-to-ready latency = WAIT_CYCLES+1 cycles.
REQ-020 A write without error SHALL commit to the array on the edge entering RESP; an errored write SHALL never modify the array.
REQ-021 A read without error SHALL load rdata with the latched-address word on the edge entering RESP; an errored read SHALL load rdata = 32'h0.
REQ-022 In RESP, ready=1 and err=latched error flag, for exactly one cycle.
REQ-023 RESP -> DONE unconditionally, with ready and err returning to 0.
REQ-024 DONE SHALL hold until memRd=0 and memWr=0 (four-phase handshake); DONE -> IDLE on the first edge where both are low.
REQ-025 Strobe, addr or wdata changes after capture SHALL be ignored until IDLE is re-entered.
REQ-026 rdata SHALL hold its last value outside RESP.
REQ-027 A read of an address in the same transaction sequence as a prior write SHALL return the written data (no stale read).

Reset
REQ-028 While reset=1: state=IDLE, ready=0, err=0, busy=0, rdata=32'h0, wait counter=0, latched registers=0.
REQ-029 Reset asserted in WAIT or RESP SHALL abort the transaction.
- A write not yet committed at the reset edge SHALL be lost.
- Array contents SHALL NOT be cleared by reset.
REQ-030 After reset deassertion, a request already high SHALL be accepted on the first rising edge.

Verification
REQ-031 WAIT_CYCLES=2: write 32'hDEADBEEF to addr 5, then read addr 5 -> ready on the 3rd edge after capture, err=0, rdata=32'hDEADBEEF.
REQ-032 Read at addr=DEPTH (256) -> ready with err=1, rdata=0; a following read of addr 0 returns unchanged contents.
REQ-033 memRd=memWr=1 at addr 7 holding 32'h1234 -> err=1; addr 7 still reads 32'h1234.
REQ-034 Strobe held high 5 cycles after ready -> state stays DONE, a single ready pulse; new request accepted only after one low cycle.
REQ-035 Reset asserted in WAIT of a write to addr 9 (old 32'hAAAA) -> outputs return to reset values; addr 9 still reads 32'hAAAA.
REQ-036 WAIT_CYCLES=0: read addr 3 -> ready on the 1st edge after capture; WAIT state never entered.
